// File: rtl/axi4_mem_responder.sv
// axi4_mem_responder
//   AXI4 slave memory for the cosim/emulation memory path. A word-organised RAM
//   served by independent write and read engines. Each engine handles one
//   transaction at a time, with INCR and FIXED bursts. WRAP bursts are walked
//   as INCR and flagged SLVERR. Reset returns both engines to idle and leaves
//   the RAM contents unchanged.
//
// Ports
//   clk_i, rst_i             clock, asynchronous active-high reset
//   s_axi_aw*_i / awready_o  write address channel (awsize ignored, full width)
//   s_axi_w*_i  / wready_o   write data channel (wstrb byte enables)
//   s_axi_b*_o  / bready_i   write response channel
//   s_axi_ar*_i / arready_o  read address channel (arsize ignored, full width)
//   s_axi_r*_o  / rready_i   read data channel
//
// Write FSM
//   state  | meaning
//   W_IDLE | awready high, waiting for AW
//   W_DATA | wready high, one RAM write per W beat
//   W_RESP | bvalid high, waiting for bready
// Read FSM
//   state  | meaning
//   R_IDLE | arready high, waiting for AR
//   R_DATA | rvalid high, current beat held in rdata_q until rready
module axi4_mem_responder #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ID_WIDTH   = 1,
  parameter int unsigned MEM_WORDS  = 4096,
  parameter string       INIT_FILE  = ""
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [ID_WIDTH-1:0]     s_axi_awid_i,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr_i,
  input  logic [7:0]              s_axi_awlen_i,
  input  logic [2:0]              s_axi_awsize_i,
  input  logic [1:0]              s_axi_awburst_i,
  input  logic                    s_axi_awvalid_i,
  output logic                    s_axi_awready_o,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb_i,
  input  logic                    s_axi_wlast_i,
  input  logic                    s_axi_wvalid_i,
  output logic                    s_axi_wready_o,
  output logic [ID_WIDTH-1:0]     s_axi_bid_o,
  output logic [1:0]              s_axi_bresp_o,
  output logic                    s_axi_bvalid_o,
  input  logic                    s_axi_bready_i,
  input  logic [ID_WIDTH-1:0]     s_axi_arid_i,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr_i,
  input  logic [7:0]              s_axi_arlen_i,
  input  logic [2:0]              s_axi_arsize_i,
  input  logic [1:0]              s_axi_arburst_i,
  input  logic                    s_axi_arvalid_i,
  output logic                    s_axi_arready_o,
  output logic [ID_WIDTH-1:0]     s_axi_rid_o,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata_o,
  output logic [1:0]              s_axi_rresp_o,
  output logic                    s_axi_rlast_o,
  output logic                    s_axi_rvalid_o,
  input  logic                    s_axi_rready_i
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned OFF    = $clog2(STRB_W);
  localparam int unsigned WAW    = ADDR_WIDTH - OFF;
  localparam int unsigned IDXW   = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef logic [WAW-1:0] waddr_t;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

  // Word addresses keep all upper address bits, so an INCR burst simply
  // carries across 4 KB and anything past the RAM decodes as out of range.
  function automatic logic word_in_range(input waddr_t a);
    return 64'(a) < 64'(MEM_WORDS);
  endfunction

  // Encodings order as OKAY < SLVERR < DECERR, so the worse one is the max.
  function automatic logic [1:0] worst(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [1:0] read_resp(input waddr_t a, input logic [1:0] burst);
    logic [1:0] r;
    r = word_in_range(a) ? RESP_OKAY : RESP_DECERR;
    if (burst == BURST_WRAP) r = worst(r, RESP_SLVERR);
    return r;
  endfunction

  logic [DATA_WIDTH-1:0] mem_q [MEM_WORDS];

  // ---------------- write engine ----------------
  w_state_e            w_state_q, w_state_d;
  logic [ID_WIDTH-1:0] w_id_q, w_id_d;
  waddr_t              w_addr_q, w_addr_d;
  logic [7:0]          w_len_q, w_len_d;
  logic [1:0]          w_burst_q, w_burst_d;
  logic [7:0]          w_cnt_q, w_cnt_d;
  logic [1:0]          w_resp_q, w_resp_d;
  logic                mem_we;
  logic                w_in_range;
  logic                w_last_beat;
  logic [1:0]          w_beat_resp;
  logic [IDXW-1:0]     w_idx;

  assign w_in_range  = word_in_range(w_addr_q);
  assign w_last_beat = (w_cnt_q == w_len_q);
  assign w_idx       = w_addr_q[IDXW-1:0];

  always_comb begin
    w_state_d   = w_state_q;
    w_id_d      = w_id_q;
    w_addr_d    = w_addr_q;
    w_len_d     = w_len_q;
    w_burst_d   = w_burst_q;
    w_cnt_d     = w_cnt_q;
    w_resp_d    = w_resp_q;
    w_beat_resp = RESP_OKAY;
    mem_we      = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (s_axi_awvalid_i) begin
          w_id_d    = s_axi_awid_i;
          w_addr_d  = s_axi_awaddr_i[ADDR_WIDTH-1:OFF];
          w_len_d   = s_axi_awlen_i;
          w_burst_d = s_axi_awburst_i;
          w_cnt_d   = '0;
          w_resp_d  = (s_axi_awburst_i == BURST_WRAP) ? RESP_SLVERR : RESP_OKAY;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (s_axi_wvalid_i) begin
          mem_we = w_in_range;
          if (!w_in_range) begin
            w_beat_resp = RESP_DECERR;
          end else if (s_axi_wlast_i != w_last_beat) begin
            w_beat_resp = RESP_SLVERR;
          end
          w_resp_d = worst(w_resp_q, w_beat_resp);
          // Termination follows the beat count; wlast only feeds the error flag.
          if (w_last_beat) begin
            w_state_d = W_RESP;
          end else begin
            w_cnt_d = w_cnt_q + 8'd1;
            if (w_burst_q != BURST_FIXED) w_addr_d = w_addr_q + waddr_t'(1);
          end
        end
      end
      W_RESP: begin
        if (s_axi_bready_i) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      w_state_q <= W_IDLE;
      w_id_q    <= '0;
      w_addr_q  <= '0;
      w_len_q   <= '0;
      w_burst_q <= '0;
      w_cnt_q   <= '0;
      w_resp_q  <= RESP_OKAY;
    end else begin
      w_state_q <= w_state_d;
      w_id_q    <= w_id_d;
      w_addr_q  <= w_addr_d;
      w_len_q   <= w_len_d;
      w_burst_q <= w_burst_d;
      w_cnt_q   <= w_cnt_d;
      w_resp_q  <= w_resp_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (s_axi_wstrb_i[b]) mem_q[w_idx][8*b +: 8] <= s_axi_wdata_i[8*b +: 8];
      end
    end
  end

  assign s_axi_awready_o = (w_state_q == W_IDLE);
  assign s_axi_wready_o  = (w_state_q == W_DATA);
  assign s_axi_bvalid_o  = (w_state_q == W_RESP);
  assign s_axi_bid_o     = w_id_q;
  assign s_axi_bresp_o   = w_resp_q;

  // ---------------- read engine ----------------
  r_state_e              r_state_q, r_state_d;
  logic [ID_WIDTH-1:0]   r_id_q, r_id_d;
  waddr_t                r_addr_q, r_addr_d;
  logic [7:0]            r_len_q, r_len_d;
  logic [1:0]            r_burst_q, r_burst_d;
  logic [7:0]            r_cnt_q, r_cnt_d;
  logic [1:0]            r_resp_q, r_resp_d;
  logic                  r_last_q, r_last_d;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  rd_load;
  waddr_t                rd_addr;
  waddr_t                ar_waddr;
  waddr_t                r_next_addr;
  logic                  rd_hit;
  logic [IDXW-1:0]       rd_idx;

  assign ar_waddr    = s_axi_araddr_i[ADDR_WIDTH-1:OFF];
  assign r_next_addr = (r_burst_q == BURST_FIXED) ? r_addr_q : r_addr_q + waddr_t'(1);

  // rd_addr names the word loaded into rdata_q at the coming edge: the first
  // beat on AR, the following beat on each R handshake, so no bubble appears.
  always_comb begin
    r_state_d = r_state_q;
    r_id_d    = r_id_q;
    r_addr_d  = r_addr_q;
    r_len_d   = r_len_q;
    r_burst_d = r_burst_q;
    r_cnt_d   = r_cnt_q;
    r_resp_d  = r_resp_q;
    r_last_d  = r_last_q;
    rd_load   = 1'b0;
    rd_addr   = r_addr_q;
    case (r_state_q)
      R_IDLE: begin
        if (s_axi_arvalid_i) begin
          rd_addr   = ar_waddr;
          rd_load   = 1'b1;
          r_id_d    = s_axi_arid_i;
          r_addr_d  = ar_waddr;
          r_len_d   = s_axi_arlen_i;
          r_burst_d = s_axi_arburst_i;
          r_cnt_d   = '0;
          r_last_d  = (s_axi_arlen_i == 8'd0);
          r_resp_d  = read_resp(ar_waddr, s_axi_arburst_i);
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (s_axi_rready_i) begin
          if (r_last_q) begin
            r_last_d  = 1'b0;
            r_state_d = R_IDLE;
          end else begin
            rd_addr  = r_next_addr;
            rd_load  = 1'b1;
            r_addr_d = r_next_addr;
            r_cnt_d  = r_cnt_q + 8'd1;
            r_last_d = ((r_cnt_q + 8'd1) == r_len_q);
            r_resp_d = read_resp(r_next_addr, r_burst_q);
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state_q <= R_IDLE;
      r_id_q    <= '0;
      r_addr_q  <= '0;
      r_len_q   <= '0;
      r_burst_q <= '0;
      r_cnt_q   <= '0;
      r_resp_q  <= RESP_OKAY;
      r_last_q  <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      r_id_q    <= r_id_d;
      r_addr_q  <= r_addr_d;
      r_len_q   <= r_len_d;
      r_burst_q <= r_burst_d;
      r_cnt_q   <= r_cnt_d;
      r_resp_q  <= r_resp_d;
      r_last_q  <= r_last_d;
    end
  end

  assign rd_hit = word_in_range(rd_addr);
  assign rd_idx = rd_addr[IDXW-1:0];

  // Sampling mem_q at the same edge as a write yields the pre-write word.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (rd_load) begin
      rdata_q <= rd_hit ? mem_q[rd_idx] : '0;
    end
  end

  assign s_axi_arready_o = (r_state_q == R_IDLE);
  assign s_axi_rvalid_o  = (r_state_q == R_DATA);
  assign s_axi_rid_o     = r_id_q;
  assign s_axi_rdata_o   = rdata_q;
  assign s_axi_rresp_o   = r_resp_q;
  assign s_axi_rlast_o   = r_last_q;

  logic unused_ok;
  assign unused_ok = ^{s_axi_awsize_i, s_axi_arsize_i,
                       s_axi_awaddr_i[OFF-1:0], s_axi_araddr_i[OFF-1:0]};

endmodule
